// File: rtl/ddl_event_sched_if.sv
// ----------------------------------------------------------------------------
// ddl_event_sched_if
// Bundles the event-buffer, DDL link and status signals of the SRU event
// scheduler into a single interface.
//
//   master : the side that drives the buffer/link inputs and observes status
//            (DTC buffer, DDL links and readout config, or a testbench)
//   slave  : the scheduler itself
//
// Signals
//   event_rdy    one-cycle pulse, an event is ready in DTC RAM
//   link_en[1:0] per-link enable from the readout config
//   ddl_xoff     per-link flow-control stop (1 = hold)
//   link_done    per-link one-cycle pulse, the event is fully read from RAM
//   err_clr      clears the sticky error flags
//   tx_start     per-link one-cycle transmit start pulse
//   ram_release  one-cycle pulse, the event buffer slot is freed
//   busy         backpressure to the trigger logic
//   pend_cnt     events pending, including the one in flight
//   timeout_err  sticky, a transmission timed out
//   ovf_err      sticky, an event arrived while the pending count was full
//   ev_sent_cnt  completed-event counter (zero when statistics are disabled)
// ----------------------------------------------------------------------------
interface ddl_event_sched_if;
    logic        event_rdy;
    logic [1:0]  link_en;
    logic [1:0]  ddl_xoff;
    logic [1:0]  link_done;
    logic        err_clr;
    logic [1:0]  tx_start;
    logic        ram_release;
    logic        busy;
    logic [3:0]  pend_cnt;
    logic        timeout_err;
    logic        ovf_err;
    logic [31:0] ev_sent_cnt;

    modport master (
        output event_rdy, link_en, ddl_xoff, link_done, err_clr,
        input  tx_start, ram_release, busy, pend_cnt, timeout_err, ovf_err,
               ev_sent_cnt
    );

    modport slave (
        input  event_rdy, link_en, ddl_xoff, link_done, err_clr,
        output tx_start, ram_release, busy, pend_cnt, timeout_err, ovf_err,
               ev_sent_cnt
    );
endinterface

// File: rtl/ddl_event_sched.sv
// ----------------------------------------------------------------------------
// ddl_event_sched
// Event scheduler between the DTC event buffer and the two DDL links of the
// EMCal SRU. It counts events announced ready, starts transmission on every
// enabled link once flow control allows, waits for each link to confirm, and
// then releases the event buffer slot. A transmission that never completes is
// force-released after TIMEOUT_CYC cycles. Everything runs in the SIU clock
// domain.
//
// Parameters
//   MAX_PEND     pending-event capacity (2..15)
//   BUSY_THR     busy asserts when pend_cnt >= BUSY_THR
//   TIMEOUT_CYC  cycles allowed in SEND before a forced release
//
// Ports
//   clk    SIU clock
//   reset  synchronous, active-high
//   bus    ddl_event_sched_if.slave (see the interface for signal meanings)
//
// Optional feature
//   DDL_SCHED_STATS_EN  when defined, ev_sent_cnt counts events released after
//                       a complete transmission (wraps, cleared by reset only);
//                       when undefined, ev_sent_cnt is tied to zero.
// ----------------------------------------------------------------------------
module ddl_event_sched #(
    parameter int unsigned MAX_PEND    = 8,
    parameter int unsigned BUSY_THR    = 6,
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
    input logic              clk,
    input logic              reset,
    ddl_event_sched_if.slave bus
);

    localparam logic [3:0] MAX_PEND_C = 4'(MAX_PEND);
    localparam logic [3:0] BUSY_THR_C = 4'(BUSY_THR);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_XON,
        START,
        SEND,
        RELEASE
    } state_t;

    state_t      state;
    logic [1:0]  mask;         // links taking part in the current event
    logic [1:0]  done_seen;    // links that already confirmed this event
    logic [15:0] timer;
    logic [3:0]  pend_cnt;
    logic [1:0]  tx_start;
    logic        ram_release;
    logic        timeout_err;
    logic        ovf_err;

    logic [1:0]  done_acc;
    logic        all_done;
    logic        timer_exp;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        done_acc  = done_seen | (bus.link_done & mask);
        all_done  = (done_acc == mask);
        // The timer is loaded with TIMEOUT_CYC on entry to SEND, so the
        // SEND cycle that sees 1 is the last one allowed.
        timer_exp = (timer <= 16'd1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mask        <= 2'b00;
            done_seen   <= 2'b00;
            timer       <= 16'd0;
            pend_cnt    <= 4'd0;
            tx_start    <= 2'b00;
            ram_release <= 1'b0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            // Strobes default low so each is high for exactly one cycle.
            tx_start    <= 2'b00;
            ram_release <= 1'b0;

            // NOTE: the clear is written before any set so that, within the
            // same edge, the later set assignment wins over err_clr.
            if (bus.err_clr) begin
                timeout_err <= 1'b0;
                ovf_err     <= 1'b0;
            end

            // Pending count: a simultaneous arrival and release cancel out.
            if (bus.event_rdy && !ram_release) begin
                if (pend_cnt == MAX_PEND_C) begin
                    ovf_err <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + 4'd1;
                end
            end else if (!bus.event_rdy && ram_release) begin
                pend_cnt <= pend_cnt - 4'd1;
            end

            unique case (state)
                IDLE: begin
                    if (pend_cnt != 4'd0) begin
                        if (bus.link_en != 2'b00) begin
                            mask  <= bus.link_en;
                            state <= WAIT_XON;
                        end else begin
                            // No link enabled: discard the event untransmitted.
                            ram_release <= 1'b1;
                            state       <= RELEASE;
                        end
                    end
                end

                WAIT_XON: begin
                    if ((bus.ddl_xoff & mask) == 2'b00) begin
                        tx_start <= mask;
                        state    <= START;
                    end
                end

                START: begin
                    done_seen <= 2'b00;
                    timer     <= TIMEOUT_CYC;
                    state     <= SEND;
                end

                SEND: begin
                    done_seen <= done_acc;
                    if (all_done) begin
                        // Completion takes priority over a simultaneous expiry.
                        ram_release <= 1'b1;
                        state       <= RELEASE;
                    end else if (timer_exp) begin
                        timeout_err <= 1'b1;
                        ram_release <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DDL_SCHED_STATS_EN
    logic        rel_ok;       // the release in progress follows a completion
    logic [31:0] ev_sent_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rel_ok      <= 1'b0;
            ev_sent_cnt <= 32'd0;
        end else begin
            rel_ok <= (state == SEND) && all_done;
            if (ram_release && rel_ok) begin
                ev_sent_cnt <= ev_sent_cnt + 32'd1;
            end
        end
    end

    assign bus.ev_sent_cnt = ev_sent_cnt;
`else
    assign bus.ev_sent_cnt = 32'd0;
`endif

    assign bus.tx_start    = tx_start;
    assign bus.ram_release = ram_release;
    assign bus.busy        = (pend_cnt >= BUSY_THR_C);
    assign bus.pend_cnt    = pend_cnt;
    assign bus.timeout_err = timeout_err;
    assign bus.ovf_err     = ovf_err;

endmodule

// File: tb/tb_ddl_event_sched.sv
// ----------------------------------------------------------------------------
// tb_ddl_event_sched
// Self-checking bench for ddl_event_sched. Directed scenarios cover reset,
// start/release latency, flow control, timeout, overflow, simultaneous
// arrival/release, link_en == 0 and reset during SEND. A randomized window is
// compared cycle by cycle against a timeline model that schedules each event
// from the stimulus arrays (when it starts, when xoff clears, when the links
// confirm or the timer expires).
// Outputs are sampled and inputs driven on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ddl_event_sched;

    localparam int MAX_PEND = 8;
    localparam int BUSY_THR = 6;
    localparam int TOUT     = 100;
    localparam int N        = 400;    // randomized window length
    localparam int L        = 1200;   // stimulus/lookahead array length

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ddl_event_sched_if bus ();

    ddl_event_sched #(
        .MAX_PEND    (MAX_PEND),
        .BUSY_THR    (BUSY_THR),
        .TIMEOUT_CYC (16'(TOUT))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus and expected timelines for the randomized window.
    logic       s_ev   [L];
    logic [1:0] s_en   [L];
    logic [1:0] s_xoff [L];
    logic [1:0] s_done [L];
    logic       s_clr  [L];
    int         e_pend [L];
    logic [1:0] e_tx   [L];
    logic       e_rel  [L];
    logic       e_tout [L];
    logic       e_ovf  [L];
    int         e_sent [L];
    logic       good   [L];
    logic       tset   [L];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic set_in(input logic ev, input logic [1:0] en, input logic [1:0] xoff,
                          input logic [1:0] done, input logic clr);
        bus.event_rdy = ev;
        bus.link_en   = en;
        bus.ddl_xoff  = xoff;
        bus.link_done = done;
        bus.err_clr   = clr;
    endtask

    // Ends on the falling edge of cycle 0: the first cycle after reset.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tx"},   32'(bus.tx_start),    32'd0);
        check({tag, ".rel"},  32'(bus.ram_release), 32'd0);
        check({tag, ".busy"}, 32'(bus.busy),        32'd0);
        check({tag, ".pend"}, 32'(bus.pend_cnt),    32'd0);
        check({tag, ".tout"}, 32'(bus.timeout_err), 32'd0);
        check({tag, ".ovf"},  32'(bus.ovf_err),     32'd0);
        check({tag, ".sent"}, bus.ev_sent_cnt,      32'd0);
    endtask

    // Timeline model: each event is placed on the time axis from the rules of
    // operation; pending count and sticky flags follow from those placements.
    task automatic build_model();
        int         idle_from;
        int         w, s, r;
        logic [1:0] m, acc;
        logic       ok, timed;
        for (int c = 0; c < L; c++) begin
            e_tx[c] = 2'b00; e_rel[c] = 1'b0; good[c] = 1'b0; tset[c] = 1'b0;
            e_pend[c] = 0; e_tout[c] = 1'b0; e_ovf[c] = 1'b0; e_sent[c] = 0;
        end
        idle_from = 0;
        for (int c = 0; c < N; c++) begin
            if (c >= idle_from && e_pend[c] > 0) begin
                m = s_en[c];
                ok = 1'b0; timed = 1'b0;
                if (m == 2'b00) begin
                    r = c + 1;
                end else begin
                    w = c + 1;
                    while (w < L && (s_xoff[w] & m) != 2'b00) w++;
                    s = w + 1;
                    r = L;
                    acc = 2'b00;
                    if (s < L) e_tx[s] = m;
                    for (int k = s + 1; k < L; k++) begin
                        acc = acc | (s_done[k] & m);
                        if (acc == m) begin r = k + 1; ok = 1'b1; break; end
                        if (k == s + TOUT) begin r = k + 1; timed = 1'b1; break; end
                    end
                end
                if (r < L) begin
                    e_rel[r] = 1'b1; good[r] = ok; tset[r] = timed;
                end
                idle_from = r + 1;
            end
            if (s_ev[c] && !e_rel[c])
                e_pend[c+1] = (e_pend[c] == MAX_PEND) ? e_pend[c] : e_pend[c] + 1;
            else if (!s_ev[c] && e_rel[c])
                e_pend[c+1] = e_pend[c] - 1;
            else
                e_pend[c+1] = e_pend[c];
            e_ovf[c+1]  = (s_ev[c] && !e_rel[c] && e_pend[c] == MAX_PEND) ||
                          (e_ovf[c] && !s_clr[c]);
            e_tout[c+1] = tset[c+1] || (e_tout[c] && !s_clr[c]);
            e_sent[c+1] = e_sent[c] + ((e_rel[c] && good[c]) ? 1 : 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc = 0;

        // ---- reset state ----
        do_reset();
        check_all_zero("reset");

        // ---- single event, both links, no xoff ----
        set_in(1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        goto_cyc(10); bus.event_rdy = 1'b1;
        step(); bus.event_rdy = 1'b0;
        check("single.pend_n1", 32'(bus.pend_cnt), 32'd1);
        goto_cyc(12); check("single.tx_n2", 32'(bus.tx_start), 32'd0);
        goto_cyc(13); check("single.tx_n3", 32'(bus.tx_start), 32'd3);
        goto_cyc(14); check("single.tx_n4", 32'(bus.tx_start), 32'd0);
        goto_cyc(20); bus.link_done = 2'b01;
        step(); bus.link_done = 2'b00;
        goto_cyc(25); bus.link_done = 2'b10;
        check("single.rel_m", 32'(bus.ram_release), 32'd0);
        step(); bus.link_done = 2'b00;
        check("single.rel_m1", 32'(bus.ram_release), 32'd1);
        check("single.pend_m1", 32'(bus.pend_cnt), 32'd1);
        step();
        check("single.rel_m2", 32'(bus.ram_release), 32'd0);
        check("single.pend_m2", 32'(bus.pend_cnt), 32'd0);
        check("single.tout", 32'(bus.timeout_err), 32'd0);

        // ---- flow control: xoff on link 1 for 40 cycles ----
        do_reset();
        set_in(1'b1, 2'b11, 2'b10, 2'b00, 1'b0);
        step(); bus.event_rdy = 1'b0;
        while (cyc < 40) begin
            check($sformatf("xoff.tx_c%0d", cyc), 32'(bus.tx_start), 32'd0);
            step();
        end
        bus.ddl_xoff = 2'b00;
        check("xoff.tx_drop", 32'(bus.tx_start), 32'd0);
        step(); check("xoff.tx_after", 32'(bus.tx_start), 32'd3);
        goto_cyc(43); bus.link_done = 2'b11;
        step(); bus.link_done = 2'b00;
        check("xoff.rel", 32'(bus.ram_release), 32'd1);
        step(); check("xoff.pend", 32'(bus.pend_cnt), 32'd0);

        // ---- timeout: only link 0 confirms ----
        do_reset();
        set_in(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
        step(); bus.event_rdy = 1'b0;
        goto_cyc(3); check("tout.tx", 32'(bus.tx_start), 32'd3);
        goto_cyc(5); bus.link_done = 2'b01;
        step(); bus.link_done = 2'b00;
        goto_cyc(3 + TOUT); check("tout.rel_early", 32'(bus.ram_release), 32'd0);
        check("tout.err_early", 32'(bus.timeout_err), 32'd0);
        goto_cyc(4 + TOUT); check("tout.rel", 32'(bus.ram_release), 32'd1);
        check("tout.err", 32'(bus.timeout_err), 32'd1);
        goto_cyc(6 + TOUT); bus.err_clr = 1'b1;
        check("tout.pend", 32'(bus.pend_cnt), 32'd0);
        check("tout.err_hold", 32'(bus.timeout_err), 32'd1);
        step(); bus.err_clr = 1'b0;
        check("tout.err_clr", 32'(bus.timeout_err), 32'd0);

        // ---- overflow with xoff held, 10 back-to-back arrivals ----
        do_reset();
        set_in(1'b1, 2'b11, 2'b11, 2'b00, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) bus.event_rdy = 1'b0;
            check($sformatf("ovf.pend_%0d", k), 32'(bus.pend_cnt), 32'((k > 8) ? 8 : k));
            check($sformatf("ovf.busy_%0d", k), 32'(bus.busy), 32'((k >= BUSY_THR) ? 1 : 0));
            check($sformatf("ovf.tx_%0d", k), 32'(bus.tx_start), 32'd0);
            if (k == 8) check("ovf.err_8", 32'(bus.ovf_err), 32'd0);
        end
        check("ovf.err", 32'(bus.ovf_err), 32'd1);
        // set and clear in the same cycle: set wins
        bus.event_rdy = 1'b1; bus.err_clr = 1'b1;
        step(); bus.event_rdy = 1'b0;
        check("ovf.set_wins", 32'(bus.ovf_err), 32'd1);
        step(); bus.err_clr = 1'b0;
        check("ovf.cleared", 32'(bus.ovf_err), 32'd0);
        check("ovf.pend_sat", 32'(bus.pend_cnt), 32'd8);

        // ---- link_en == 0, arrival coinciding with a release ----
        do_reset();
        set_in(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        goto_cyc(3); bus.event_rdy = 1'b0;
        check("disc.pend_same", 32'(bus.pend_cnt), 32'd2);
        cyc = 3;
        while (cyc < 12) begin
            check($sformatf("disc.rel_c%0d", cyc), 32'(bus.ram_release),
                  32'((cyc == 4 || cyc == 6) ? 1 : 0));
            check($sformatf("disc.tx_c%0d", cyc), 32'(bus.tx_start), 32'd0);
            if (cyc == 7) check("disc.pend_end", 32'(bus.pend_cnt), 32'd0);
            step();
        end

        // ---- reset during SEND ----
        do_reset();
        set_in(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
        step(); bus.event_rdy = 1'b0;
        goto_cyc(5); reset = 1'b1;
        step(); reset = 1'b0;
        check_all_zero("rstsend");
        bus.link_done = 2'b11;
        step(); bus.link_done = 2'b00;
        while (cyc < 16) begin
            check($sformatf("rstsend.rel_c%0d", cyc), 32'(bus.ram_release), 32'd0);
            check($sformatf("rstsend.tx_c%0d", cyc), 32'(bus.tx_start), 32'd0);
            step();
        end

        // ---- randomized window against the timeline model ----
        for (int c = 0; c < L; c++) begin
            s_ev[c]   = ($urandom_range(0, 7) == 0);
            s_en[c]   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            s_xoff[c] = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            s_done[c] = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            s_clr[c]  = ($urandom_range(0, 24) == 0);
        end
        build_model();
        do_reset();
        for (int c = 0; c < N; c++) begin
            check($sformatf("rnd.tx_c%0d", c),   32'(bus.tx_start),    32'(e_tx[c]));
            check($sformatf("rnd.rel_c%0d", c),  32'(bus.ram_release), 32'(e_rel[c]));
            check($sformatf("rnd.pend_c%0d", c), 32'(bus.pend_cnt),    32'(e_pend[c]));
            check($sformatf("rnd.busy_c%0d", c), 32'(bus.busy),        32'((e_pend[c] >= BUSY_THR) ? 1 : 0));
            check($sformatf("rnd.tout_c%0d", c), 32'(bus.timeout_err), 32'(e_tout[c]));
            check($sformatf("rnd.ovf_c%0d", c),  32'(bus.ovf_err),     32'(e_ovf[c]));
`ifdef DDL_SCHED_STATS_EN
            check($sformatf("rnd.sent_c%0d", c), bus.ev_sent_cnt,      32'(e_sent[c]));
`else
            check($sformatf("rnd.sent_c%0d", c), bus.ev_sent_cnt,      32'd0);
`endif
            set_in(s_ev[c], s_en[c], s_xoff[c], s_done[c], s_clr[c]);
            step();
        end
        set_in(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddl_event_sched.md
# ddl_event_sched

Event scheduler between the DTC event buffer and the two DDL link interfaces of the EMCal SRU. It counts events announced ready, starts transmission on every enabled link once flow control allows, and waits for each link to confirm. It then releases the event buffer slot, with timeout protection and a busy indication for the trigger path. All logic runs in the SIU clock domain (`siu_foCLK[0]`).

## Interface
Parameters:
- `MAX_PEND`, default 8: pending-event capacity (2..15).
- `BUSY_THR`, default 6: `busy` asserts when `pend_cnt >= BUSY_THR`.
- `TIMEOUT_CYC`, default 16'd65535: cycles allowed in SEND before forced release (16-bit).

Ports:
- `clk`, in, 1: SIU clock.
- `reset`, in, 1: synchronous, active-high.
- `event_rdy`, in, 1: one-cycle pulse, one event ready in DTC RAM.
- `link_en`, in, 2: per-link enable from readout config.
- `ddl_xoff`, in, 2: per-link flow-control stop (1 = hold).
- `link_done`, in, 2: per-link one-cycle pulse, event fully read from RAM.
- `err_clr`, in, 1: clears sticky flags.
- `tx_start`, out, 2: one-cycle start pulse per link.
- `ram_release`, out, 1: one-cycle pulse, event slot freed.
- `busy`, out, 1: backpressure to trigger logic.
- `pend_cnt`, out, 4: events pending, including the one in flight.
- `timeout_err`, out, 1: sticky, a SEND timed out.
- `ovf_err`, out, 1: sticky, `event_rdy` arrived at `MAX_PEND`.
- `ev_sent_cnt`, out, 32: completed-event counter (see Configuration).

## Operation
- States: IDLE, WAIT_XON, START, SEND, RELEASE.
- IDLE:
  - If `pend_cnt > 0` and `link_en != 0`, latch `mask <= link_en` and go to WAIT_XON.
  - If `pend_cnt > 0` and `link_en == 0`, go to RELEASE. The event is discarded and nothing is transmitted.
- WAIT_XON: when `(ddl_xoff & mask) == 0`, go to START. Otherwise hold indefinitely; this state has no timeout.
- START: `tx_start = mask` for this cycle only. Clear `done_seen`, load the timer with `TIMEOUT_CYC`, then go to SEND.
- SEND:
  - Each cycle, `done_seen |= link_done & mask`. Done pulses from unmasked links are ignored.
  - When `(done_seen | (link_done & mask)) == mask`, go to RELEASE.
  - Otherwise the timer decrements. When it reaches 0, set `timeout_err` and go to RELEASE.
  - If completion and timer expiry occur in the same cycle, completion wins and `timeout_err` is not set.
- RELEASE: `ram_release = 1` for one cycle, `pend_cnt` decrements, next state IDLE.
- `link_done` outside SEND is ignored.
- `link_en` changes take effect only at the next IDLE exit, because `mask` is frozen per event.
- pend_cnt:
  - Increments on `event_rdy` and decrements on `ram_release`.
  - If both occur in the same cycle, it is unchanged.
  - At `MAX_PEND`, an `event_rdy` without a simultaneous release does not increment; set `ovf_err` instead.
  - It never underflows, because release happens only with `pend_cnt > 0`.
- `busy` is combinational from the `pend_cnt` register: `pend_cnt >= BUSY_THR`.
- `err_clr` clears `timeout_err` and `ovf_err`. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset values:
  - State IDLE.
  - `tx_start = 0`, `ram_release = 0`, `busy = 0`, `pend_cnt = 0`.
  - `timeout_err = 0`, `ovf_err = 0`, `ev_sent_cnt = 0`, `mask = 0`, `done_seen = 0`.
- Reset mid-event: immediate return to IDLE. The pending count is lost and no `tx_start` or `ram_release` pulse is emitted afterwards.
- `tx_start` and `ram_release` are registered, decoded from state, and high for exactly one cycle.
- Event start latency, with `event_rdy` sampled at cycle n:
  - `pend_cnt = 1` at n+1.
  - WAIT_XON at n+2.
  - `tx_start` high at n+3 if xoff is clear.
- Release latency: last required `link_done` at cycle m gives `ram_release` at m+1, `pend_cnt` decremented at m+2, IDLE at m+2.
- Back-to-back events: at least 5 cycles per event (IDLE, WAIT_XON, START, SEND ≥1, RELEASE).
- Timeout: `ram_release` occurs `TIMEOUT_CYC + 1` cycles after the `tx_start` cycle when no completion arrives.

## Configuration
- `DDL_SCHED_STATS_EN` defined:
  - `ev_sent_cnt` increments by 1 on every `ram_release` that completed without timeout and with `mask != 0`.
  - It wraps from 32'hFFFFFFFF to 0 and is cleared by `reset` only.
- `DDL_SCHED_STATS_EN` not defined: the counter logic is absent and `ev_sent_cnt` is tied to 32'h0. All other behaviour is identical.

## Test plan
- Single event, `link_en = 2'b11`, no xoff:
  - `event_rdy` at cycle 10 gives `tx_start = 2'b11` at cycle 13.
  - `link_done` of 01 at cycle 20 and 10 at cycle 25 gives `ram_release` at cycle 26 and `pend_cnt = 0` at cycle 27.
- Flow control: `ddl_xoff = 2'b10` held for 40 cycles with `link_en = 2'b11`. `tx_start` is delayed until one cycle after xoff drops and stays 0 before that.
- Timeout with `TIMEOUT_CYC = 100`: only link 0 reports done. `ram_release` occurs 101 cycles after `tx_start`, `timeout_err = 1`, and `err_clr` then returns it to 0.
- Overflow with `MAX_PEND = 8`, xoff held: 10 `event_rdy` pulses give `pend_cnt = 8`, `ovf_err = 1`, and `busy = 1` from the 6th pulse onward.
- Simultaneous events: `event_rdy` in the same cycle as `ram_release` leaves `pend_cnt` unchanged. `link_en = 2'b00` with 3 pending gives 3 `ram_release` pulses and no `tx_start`.
- Reset mid-SEND: `reset` during SEND gives all outputs at reset values the next cycle, and a later `link_done` produces no `ram_release`.
- With `DDL_SCHED_STATS_EN`: 5 clean events and 1 timed-out event give `ev_sent_cnt = 5`.
